// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses and edge-capture modes.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, one-cycle history register and edge pulse generation for the PIO.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev_q <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_pulse = in_sync & ~in_prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse = ~in_sync & in_prev_q;
      EDGE_ANY:  edge_pulse = in_sync ^ in_prev_q;
      default:   edge_pulse = in_sync & ~in_prev_q;
    endcase
  end

endmodule

// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM GPIO slave with direction, edge capture and irq.
// Define PIO_BITSET_EN to enable the outset (4) / outclear (5) registers.
module avalon_pio_gen
  import pio_pkg::*;
#(
  parameter int unsigned    WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned    EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned    SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic [WIDTH-1:0] in_sync, edge_pulse, wd, rd_val;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .in_sync   (in_sync),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr) begin
      case (address)
        ADDR_DATA:    out_d  = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET:  out_d  = out_q | wd;
        ADDR_OUTCLR:  out_d  = out_q & ~wd;
`else
        ADDR_OUTSET, ADDR_OUTCLR: ;
`endif
        default: ;
      endcase
    end
  end

  // A new edge overrides a simultaneous write-1-clear on the same bit.
  always_comb begin
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~wd;
    edgecap_d = edgecap_d | edge_pulse;
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (dir_q & out_q) | (~dir_q & in_sync);
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = mask_q;
      ADDR_EDGECAP: rd_val = edgecap_q;
      default:      rd_val = '0;
    endcase
    readdata_d = '0;
    readdata_d[WIDTH-1:0] = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= RESET_VALUE;
      dir_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & mask_q);
    end
  end

  assign out_port = out_q;
  assign oe       = dir_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_gen.sv
// Self-checking bench for avalon_pio_gen: rising-edge and any-edge instances share one bus.
module tb_avalon_pio_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata0, readdata2;
  logic [7:0]  out0, out2, oe0, oe2;
  logic        irq0, irq2;

  always #5 clk = ~clk;

  avalon_pio_gen #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata0),
    .in_port(in_port), .out_port(out0), .oe(oe0), .irq(irq0)
  );

  avalon_pio_gen #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port), .out_port(out2), .oe(oe2), .irq(irq2)
  );

`ifdef PIO_BITSET_EN
  localparam logic [7:0] ExpSet = 8'hF3;
  localparam logic [7:0] ExpClr = 8'hC3;
`else
  localparam logic [7:0] ExpSet = 8'h33;
  localparam logic [7:0] ExpClr = 8'h33;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] e0;
    logic [31:0] e2;
  } sb_t;

  vec_t vecs[10];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e2);
    sb_t s;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    s.a = a; s.e0 = e0; s.e2 = e2;
    sbq.push_back(s);
    cyc();
    chipselect = 1'b0;
    s = sbq.pop_front();
    check($sformatf("rd0 addr%0d", s.a), readdata0, s.e0);
    check($sformatf("rd2 addr%0d", s.a), readdata2, s.e2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'h0000_0000, 8'h3C, 3'd0, 32'h0000_003C, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 3'd1, 32'h0000_00F0, 8'h0F, 3'd1, 32'h0000_00F0, 8'hA5, 8'hF0};
    vecs[2] = '{1'b1, 3'd0, 32'h0000_005A, 8'h0F, 3'd0, 32'h0000_005F, 8'h5A, 8'hF0};
    vecs[3] = '{1'b1, 3'd0, 32'hFFFF_FF33, 8'h0F, 3'd0, 32'h0000_003F, 8'h33, 8'hF0};
    vecs[4] = '{1'b1, 3'd6, 32'h0000_00FF, 8'h0F, 3'd6, 32'h0000_0000, 8'h33, 8'hF0};
    vecs[5] = '{1'b1, 3'd7, 32'h0000_00FF, 8'h0F, 3'd7, 32'h0000_0000, 8'h33, 8'hF0};
    vecs[6] = '{1'b1, 3'd4, 32'h0000_00F0, 8'h0F, 3'd4, 32'h0000_0000, ExpSet, 8'hF0};
    vecs[7] = '{1'b1, 3'd5, 32'h0000_003C, 8'h0F, 3'd5, 32'h0000_0000, ExpClr, 8'hF0};
    vecs[8] = '{1'b1, 3'd1, 32'h0000_0000, 8'h00, 3'd0, 32'h0000_0000, ExpClr, 8'h00};
    vecs[9] = '{1'b1, 3'd2, 32'h0000_00A3, 8'h00, 3'd2, 32'h0000_00A3, ExpClr, 8'h00};

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    cyc(); cyc();
    check("reset out_port", 32'(out0), 32'h0000_00A5);
    check("reset oe", 32'(oe0), 32'h0);
    check("reset irq", 32'(irq0), 32'h0);
    check("reset readdata", readdata0, 32'h0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      in_port = vecs[i].inp;
      cyc(); cyc(); cyc();
      if (vecs[i].wr) wr_reg(vecs[i].waddr, vecs[i].wd);
      rd_reg(vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d out_port", i), 32'(out0), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d oe", i), 32'(oe0), 32'(vecs[i].exp_oe));
    end

    // Rising edge on bit2: visible exactly SYNC_STAGES+1 cycles after the pin change.
    wr_reg(3'd3, 32'hFF);
    rd_reg(3'd3, 32'h00, 32'h00);
    in_port = 8'h04;
    cyc(); cyc();
    rd_reg(3'd3, 32'h00, 32'h00);
    rd_reg(3'd3, 32'h04, 32'h04);
    check("irq masked", 32'(irq0), 32'h0);
    wr_reg(3'd2, 32'h04);
    check("irq before unmask lands", 32'(irq0), 32'h0);
    cyc();
    check("irq after unmask", 32'(irq0), 32'h1);
    wr_reg(3'd3, 32'h04);
    check("irq held during clear", 32'(irq0), 32'h1);
    cyc();
    check("irq after clear", 32'(irq0), 32'h0);
    rd_reg(3'd3, 32'h00, 32'h00);

    // Clear and new edge on the same bit in the same cycle: the set wins.
    in_port = 8'h00;
    cyc(); cyc(); cyc(); cyc();
    wr_reg(3'd3, 32'hFF);
    in_port = 8'h04;
    cyc(); cyc();
    wr_reg(3'd3, 32'h04);
    rd_reg(3'd3, 32'h04, 32'h04);

    // Falling edge on bit0 is captured only by the any-edge instance.
    in_port = 8'h01;
    cyc(); cyc(); cyc(); cyc();
    wr_reg(3'd3, 32'hFF);
    in_port = 8'h00;
    cyc(); cyc(); cyc(); cyc();
    rd_reg(3'd3, 32'h00, 32'h01);

    // Reset while irq is high and every bit captured.
    wr_reg(3'd1, 32'h0F);
    wr_reg(3'd2, 32'hFF);
    in_port = 8'hFF;
    cyc(); cyc(); cyc(); cyc();
    check("irq before reset", 32'(irq0), 32'h1);
    rd_reg(3'd3, 32'hFF, 32'hFF);
    reset = 1'b1;
    in_port = 8'h00;
    cyc();
    check("mid reset out_port", 32'(out0), 32'h0000_00A5);
    check("mid reset oe", 32'(oe0), 32'h0);
    check("mid reset irq0", 32'(irq0), 32'h0);
    check("mid reset irq2", 32'(irq2), 32'h0);
    check("mid reset readdata", readdata0, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    rd_reg(3'd3, 32'h00, 32'h00);
    rd_reg(3'd2, 32'h00, 32'h00);
    rd_reg(3'd0, 32'h00, 32'h00);
    check("post reset out_port", 32'(out0), 32'h0000_00A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
